pwm_capture: RTL and testbench

Measures an external PWM or pulse-train signal on a GPIO pin and decodes it back into the 4-bit brightness/duty level used by the irrigation light controller, together with the raw period and high time in clock cycles. It is the receive-side counterpart of the LED PWM generator. It sits between a GPIO input and the top level, where its level output drives a HEX display or feeds the pump and light logic, for example from a PWM-output soil-moisture sensor or a loop-back check of the LED drive.

---
 rtl/irrigation_pkg.sv | 13 +
 rtl/pwm_capture_if.sv | 27 ++
 rtl/pwm_div4.sv | 92 +++++++++
 rtl/pwm_capture.sv | 166 ++++++++++++++++
 tb/tb_pwm_capture.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation light controller blocks.
package irrigation_pkg;

  localparam int CNT_W_DEFAULT = 28;
  localparam int CLK_HZ        = 50_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DIV  = 2'd2
  } cap_state_e;

endpackage : irrigation_pkg

// File: rtl/pwm_capture_if.sv
// Measurement bus of pwm_capture: raw GPIO input in, decoded duty and raw timing out.
interface pwm_capture_if
  import irrigation_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             pwm_in;
  logic [3:0]       level;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             overrun;
  logic             stuck;

  // master: whoever drives the pin and consumes the measurement.
  modport master (
    output pwm_in,
    input  level, period, high_time, valid, overrun, stuck
  );

  modport slave (
    input  pwm_in,
    output level, period, high_time, valid, overrun, stuck
  );

endinterface : pwm_capture_if

// File: rtl/pwm_div4.sv
// Iterative 4-step restoring divider: quot = floor(16*h/p) for h <= p, one bit per cycle.
module pwm_div4 #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] h,
  input  logic [CNT_W-1:0] p,
  output logic             done,
  output logic [3:0]       quot,
  output logic [CNT_W-1:0] h_held,
  output logic [CNT_W-1:0] p_held
);

  logic             busy_q, busy_d;
  logic [1:0]       step_q, step_d;
  logic [CNT_W:0]   rem_q, rem_d;
  logic [3:0]       quot_q, quot_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] p_q, p_d;

  logic [CNT_W:0]   rem_sh;
  logic [CNT_W:0]   rem_step;
  logic             bit_ge;
  logic [3:0]       quot_next;

  // With h <= p the remainder stays below p after every step, so the shifted
  // value always fits in CNT_W+1 bits and nothing is lost off the top.
  always_comb begin
    rem_sh    = rem_q << 1;
    bit_ge    = (rem_sh >= {1'b0, p_q});
    rem_step  = bit_ge ? (rem_sh - {1'b0, p_q}) : rem_sh;
    quot_next = {quot_q[2:0], bit_ge};
  end

  // NOTE: every variable of a combinational block gets a default first, so no
  // path through the if/else leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    step_d = step_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    h_d    = h_q;
    p_d    = p_q;
    done   = 1'b0;

    if (start) begin
      busy_d = 1'b1;
      step_d = 2'd0;
      rem_d  = {1'b0, h};
      quot_d = 4'd0;
      h_d    = h;
      p_d    = p;
    end else if (busy_q) begin
      rem_d  = rem_step;
      quot_d = quot_next;
      step_d = step_q + 2'd1;
      if (step_q == 2'd3) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // NOTE: the datapath registers are reset too; after reset nothing stale may
  // leak into an output, even if start is never seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      step_q <= 2'd0;
      rem_q  <= '0;
      quot_q <= 4'd0;
      h_q    <= '0;
      p_q    <= '0;
    end else begin
      busy_q <= busy_d;
      step_q <= step_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
      h_q    <= h_d;
      p_q    <= p_d;
    end
  end

  assign quot   = quot_next;
  assign h_held = h_q;
  assign p_held = p_q;

endmodule : pwm_div4

// File: rtl/pwm_capture.sv
// PWM receiver: measures period/high time of pwm_in and decodes the 4-bit duty level.
// Optional stuck-line timeout is built when PWM_CAPTURE_TIMEOUT_EN is defined.
module pwm_capture
  import irrigation_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(249_999_999)
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  cap_state_e       state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic             s_dly_q, s_dly_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [3:0]       level_q, level_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic             s;
  logic             rise_det;
  logic             div_start;
  logic             div_done;
  logic [3:0]       div_quot;
  logic [CNT_W-1:0] div_h;
  logic [CNT_W-1:0] div_p;

  always_comb begin
    sync_d   = {sync_q[0], bus.pwm_in};
    s        = sync_q[1];
    s_dly_d  = s;
    rise_det = s & ~s_dly_q;
  end

  // Both counters restart at 1 on a rising edge: the edge cycle itself is high.
  always_comb begin
    if (rise_det) begin
      period_cnt_d = CNT_ONE;
      high_cnt_d   = CNT_ONE;
    end else begin
      period_cnt_d = (period_cnt_q != '1) ? period_cnt_q + CNT_ONE : period_cnt_q;
      high_cnt_d   = (s && high_cnt_q != '1) ? high_cnt_q + CNT_ONE : high_cnt_q;
    end
  end

`ifdef PWM_CAPTURE_TIMEOUT_EN
  logic stuck_q, stuck_d;
`endif

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    div_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise_det) state_d = RUN;
      end
      RUN: begin
        if (rise_det) begin
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: begin
        // An edge here still restarts the counters but its period is lost.
        if (rise_det) overrun_d = 1'b1;
        if (div_done) begin
          level_d  = div_quot;
          period_d = div_p;
          high_d   = div_h;
          valid_d  = 1'b1;
          state_d  = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PWM_CAPTURE_TIMEOUT_EN
    stuck_d = stuck_q;
    if (rise_det) begin
      stuck_d = 1'b0;
    end else if (state_q != DIV && !stuck_q && period_cnt_q == TIMEOUT) begin
      stuck_d  = 1'b1;
      level_d  = s ? 4'hF : 4'h0;
      period_d = '0;
      high_d   = '0;
      valid_d  = 1'b1;
      state_d  = IDLE;
    end
`endif
  end

  pwm_div4 #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk    (CLOCK_50),
    .rst    (reset),
    .start  (div_start),
    .h      (high_cnt_q),
    .p      (period_cnt_q),
    .done   (div_done),
    .quot   (div_quot),
    .h_held (div_h),
    .p_held (div_p)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sync_q       <= 2'b00;
      s_dly_q      <= 1'b0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      level_q      <= 4'd0;
      period_q     <= '0;
      high_q       <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      s_dly_q      <= s_dly_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      level_q      <= level_d;
      period_q     <= period_d;
      high_q       <= high_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef PWM_CAPTURE_TIMEOUT_EN
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) stuck_q <= 1'b0;
    else       stuck_q <= stuck_d;
  end

  assign bus.stuck = stuck_q;
`else
  // TIMEOUT below 8 is unsupported; this empty block flags it in the hierarchy.
  if (TIMEOUT < CNT_W'(8)) begin : g_timeout_below_min
  end

  assign bus.stuck = 1'b0;
`endif

  assign bus.level     = level_q;
  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.valid     = valid_q;
  assign bus.overrun   = overrun_q;

endmodule : pwm_capture

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture; expected values computed by hand from P and H.
module tb_pwm_capture;
  import irrigation_pkg::*;

  localparam int            W  = 28;
  localparam logic [W-1:0]  TO = 28'd100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #10 clk = ~clk;

  pwm_capture_if #(.CNT_W(W)) bus ();

  pwm_capture #(
    .CNT_W   (W),
    .TIMEOUT (TO)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  int           cyc            = 0;
  int           valid_count    = 0;
  int           last_valid_cyc = 0;
  int           last_gap       = 0;
  logic [3:0]   last_level     = 4'd0;
  logic [W-1:0] last_period    = '0;
  logic [W-1:0] last_high      = '0;
  logic         prev_valid     = 1'b0;
  logic         consec_seen    = 1'b0;

  // Observes the outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      prev_valid <= bus.valid;
      if (bus.valid) begin
        valid_count    <= valid_count + 1;
        last_level     <= bus.level;
        last_period    <= bus.period;
        last_high      <= bus.high_time;
        last_gap       <= cyc - last_valid_cyc;
        last_valid_cyc <= cyc;
        if (prev_valid) consec_seen <= 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      bus.pwm_in = 1'b1;
      tick(hi);
      bus.pwm_in = 1'b0;
      tick(lo);
    end
  endtask

  task automatic check_measure(input string name, input logic [3:0] lvl,
                               input logic [W-1:0] per, input logic [W-1:0] hi);
    checks++;
    if (last_level !== lvl) begin
      errors++;
      $display("FAIL %s_level: got %0d expected %0d", name, last_level, lvl);
    end
    checks++;
    if (last_period !== per) begin
      errors++;
      $display("FAIL %s_period: got %0d expected %0d", name, last_period, per);
    end
    checks++;
    if (last_high !== hi) begin
      errors++;
      $display("FAIL %s_high: got %0d expected %0d", name, last_high, hi);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.pwm_in = 1'b0;
    tick(3);
    checks++;
    if ({bus.level, bus.period, bus.high_time, bus.valid, bus.overrun, bus.stuck} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got lvl=%0d per=%0d hi=%0d v=%b ov=%b st=%b expected all 0",
               bus.level, bus.period, bus.high_time, bus.valid, bus.overrun, bus.stuck);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_square;
    int v0;
    v0 = valid_count;
    drive(4, 4, 1);
    checks++;
    if (valid_count !== v0) begin
      errors++;
      $display("FAIL square_first_period: got %0d valids expected 0", valid_count - v0);
    end
    drive(4, 4, 7);
    tick(20);
    checks++;
    if (valid_count - v0 !== 7) begin
      errors++;
      $display("FAIL square_valid_count: got %0d expected 7", valid_count - v0);
    end
    check_measure("square", 4'd8, 28'd8, 28'd4);
    checks++;
    if (last_gap !== 8) begin
      errors++;
      $display("FAIL square_valid_gap: got %0d expected 8", last_gap);
    end
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL square_overrun: got %b expected 0", bus.overrun);
    end
  endtask

  task automatic test_min_period;
    drive(2, 3, 8);
    tick(20);
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL min_period_overrun: got %b expected 0", bus.overrun);
    end
    check_measure("min_period", 4'd6, 28'd5, 28'd2);
  endtask

  task automatic test_led3;
    drive(3, 13, 6);
    tick(20);
    check_measure("led3", 4'd3, 28'd16, 28'd3);
  endtask

  task automatic test_overrun;
    drive(2, 2, 10);
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b expected 1", bus.overrun);
    end
    drive(6, 10, 6);
    tick(20);
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b expected 1", bus.overrun);
    end
    check_measure("overrun_slow", 4'd6, 28'd16, 28'd6);
  endtask

  task automatic test_reset_mid_div;
    int v0;
    v0 = valid_count;
    bus.pwm_in = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.level, bus.period, bus.high_time, bus.valid, bus.overrun, bus.stuck} !== '0) begin
      errors++;
      $display("FAIL middiv_outputs: got lvl=%0d per=%0d hi=%0d v=%b ov=%b st=%b expected all 0",
               bus.level, bus.period, bus.high_time, bus.valid, bus.overrun, bus.stuck);
    end
    bus.pwm_in = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(12);
    checks++;
    if (valid_count !== v0) begin
      errors++;
      $display("FAIL middiv_no_valid: got %0d valids expected 0", valid_count - v0);
    end
    drive(4, 4, 1);
    checks++;
    if (valid_count !== v0) begin
      errors++;
      $display("FAIL middiv_first_edge: got %0d valids expected 0", valid_count - v0);
    end
    drive(4, 4, 1);
    tick(12);
    checks++;
    if (valid_count - v0 !== 1) begin
      errors++;
      $display("FAIL middiv_second_edge: got %0d valids expected 1", valid_count - v0);
    end
    check_measure("middiv", 4'd8, 28'd8, 28'd4);
  endtask

  task automatic test_full_and_empty;
    int v0;
    drive(9, 1, 5);
    tick(8);
    check_measure("near_full", 4'd14, 28'd10, 28'd9);
    v0 = valid_count;
    drive(1, 16, 5);
    tick(10);
    checks++;
    if (valid_count - v0 !== 5) begin
      errors++;
      $display("FAIL near_empty_count: got %0d expected 5", valid_count - v0);
    end
    check_measure("near_empty", 4'd0, 28'd17, 28'd1);
  endtask

  task automatic test_timeout;
    int v0;
    rst = 1'b1;
    bus.pwm_in = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    v0 = valid_count;
    bus.pwm_in = 1'b1;
    tick(150);
`ifdef PWM_CAPTURE_TIMEOUT_EN
    checks++;
    if (valid_count - v0 !== 1) begin
      errors++;
      $display("FAIL timeout_valid_count: got %0d expected 1", valid_count - v0);
    end
    checks++;
    if (bus.stuck !== 1'b1) begin
      errors++;
      $display("FAIL timeout_stuck: got %b expected 1", bus.stuck);
    end
    check_measure("timeout", 4'd15, 28'd0, 28'd0);
    bus.pwm_in = 1'b0;
    tick(3);
    bus.pwm_in = 1'b1;
    tick(4);
    checks++;
    if (bus.stuck !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b expected 0", bus.stuck);
    end
`else
    checks++;
    if (valid_count !== v0) begin
      errors++;
      $display("FAIL held_high_no_valid: got %0d valids expected 0", valid_count - v0);
    end
    checks++;
    if (bus.stuck !== 1'b0) begin
      errors++;
      $display("FAIL held_high_stuck: got %b expected 0", bus.stuck);
    end
`endif
    bus.pwm_in = 1'b0;
    tick(10);
  endtask

  task automatic test_valid_spacing;
    checks++;
    if (consec_seen !== 1'b0) begin
      errors++;
      $display("FAIL valid_back_to_back: got %b expected 0", consec_seen);
    end
  endtask

  initial begin
    bus.pwm_in = 1'b0;
    test_reset();
    test_square();
    test_min_period();
    test_led3();
    test_overrun();
    test_reset_mid_div();
    test_full_and_empty();
    test_timeout();
    test_valid_spacing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pwm_capture
